// File: rtl/keypad_scan.sv
// keypad_scan: scans a 4x4 active-low hex keypad one column at a time and
// debounces the row returns. Each accepted key is reported once and its hex
// digit is shifted into a six-digit entry register that feeds a display.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   row[3:0]   keypad rows, active-low with pull-ups, asynchronous to clk
//   clr        synchronous clear of the entry register
//   col[3:0]   keypad column drive, active-low, exactly one bit low
//   key_code   code of the last accepted key (holds between pulses)
//   key_valid  one-clk pulse per accepted key
//   entry      six hex digits, newest digit in [3:0]
module keypad_scan #(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_TICKS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  input  logic        clr,
  output logic [3:0]  col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic [23:0] entry
);

  localparam int unsigned TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_TICKS + 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          row_meta_q, row_meta_d;
  logic [3:0]          row_s_q, row_s_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [1:0]          colsel_q, colsel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          cand_row_q, cand_row_d;
  logic [1:0]          cand_col_q, cand_col_d;
  logic [3:0]          col_q, col_d;
  logic [3:0]          key_code_q, key_code_d;
  logic                key_valid_q, key_valid_d;
  logic [23:0]         entry_q, entry_d;

  logic                tick_c;
  logic                hit_c;
  logic [1:0]          sel_row_c;
  logic                cnt_last_c;
  logic                accept_c;
  logic [3:0]          cand_code_c;

  // Hex value printed on the key at (row r, column c).
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Datapath: row synchroniser, free-running scan tick, row decode.
  always_comb begin
    row_meta_d = row;
    row_s_d    = row_meta_q;
    tick_c     = (tick_cnt_q == TICK_W'(SCAN_DIV - 1));
    tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
    hit_c      = (row_s_q != 4'b1111);
    // Lowest-numbered low row wins when several keys share the column.
    if (!row_s_q[0])      sel_row_c = 2'd0;
    else if (!row_s_q[1]) sel_row_c = 2'd1;
    else if (!row_s_q[2]) sel_row_c = 2'd2;
    else                  sel_row_c = 2'd3;
    cnt_last_c  = (cnt_q == CNT_W'(DEBOUNCE_TICKS - 1));
    accept_c    = tick_c && (state_q == ST_DEBOUNCE) && !row_s_q[cand_row_q] && cnt_last_c;
    cand_code_c = key_map(cand_row_q, cand_col_q);
  end

  // State register and all other flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SCAN;
      row_meta_q  <= 4'b1111;
      row_s_q     <= 4'b1111;
      tick_cnt_q  <= '0;
      colsel_q    <= 2'd0;
      cnt_q       <= '0;
      cand_row_q  <= 2'd0;
      cand_col_q  <= 2'd0;
      col_q       <= 4'b1110;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      entry_q     <= 24'h0;
    end else begin
      state_q     <= state_d;
      row_meta_q  <= row_meta_d;
      row_s_q     <= row_s_d;
      tick_cnt_q  <= tick_cnt_d;
      colsel_q    <= colsel_d;
      cnt_q       <= cnt_d;
      cand_row_q  <= cand_row_d;
      cand_col_q  <= cand_col_d;
      col_q       <= col_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      entry_q     <= entry_d;
    end
  end

  // Next-state logic: every decision is taken on a scan tick only.
  always_comb begin
    state_d    = state_q;
    colsel_d   = colsel_q;
    cnt_d      = cnt_q;
    cand_row_d = cand_row_q;
    cand_col_d = cand_col_q;
    if (tick_c) begin
      case (state_q)
        ST_SCAN: begin
          if (hit_c) begin
            cand_row_d = sel_row_c;
            cand_col_d = colsel_q;
            cnt_d      = CNT_W'(1);
            state_d    = ST_DEBOUNCE;
          end else begin
            colsel_d = colsel_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (!row_s_q[cand_row_q]) begin
            if (cnt_last_c) begin
              cnt_d   = '0;
              state_d = ST_HOLD;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d    = '0;
            colsel_d = colsel_q + 2'd1;
            state_d  = ST_SCAN;
          end
        end
        ST_HOLD: begin
          // Any low row during the release window restarts it.
          if (!hit_c) begin
            if (cnt_last_c) begin
              cnt_d    = '0;
              colsel_d = colsel_q + 2'd1;
              state_d  = ST_SCAN;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_SCAN;
        end
      endcase
    end
  end

  // Output logic: registered column drive, key report and entry shift (clr wins).
  always_comb begin
    col_d       = ~(4'b0001 << colsel_d);
    key_valid_d = accept_c;
    key_code_d  = accept_c ? cand_code_c : key_code_q;
    if (clr)           entry_d = 24'h0;
    else if (accept_c) entry_d = {entry_q[19:0], cand_code_c};
    else               entry_d = entry_q;
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign entry     = entry_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_TICKS=3. A keypad model
// pulls row r low while column c is driven low and key (r,c) is pressed.
// Expected key reports are queued when a key is pressed and compared when
// key_valid is seen.
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic        clr;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [23:0] entry;

  logic [15:0] pressed;

  typedef struct {
    logic [3:0]  code;
    logic [23:0] entry;
  } exp_t;

  typedef struct {
    int          r;
    int          c;
    logic [3:0]  code;
    logic [23:0] entry;
  } vec_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [23:0] exp_entry;
  vec_t        tbl[7];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int pulse_count = 0;
  int last_pulse_cyc = 0;
  int c0;
  int p0;
  int n;

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_TICKS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .clr       (clr),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .entry     (entry)
  );

  always #5 clk = ~clk;

  // Keypad matrix model.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push_key(input logic [3:0] code, input bit clr_wins);
    exp_t e;
    exp_entry = clr_wins ? 24'h0 : {exp_entry[19:0], code};
    e.code  = code;
    e.entry = exp_entry;
    exp_q.push_back(e);
  endtask

  // Returns at the first negedge after col switches to target.
  task automatic wait_col(input logic [3:0] target);
    int k = 0;
    while (col === target && k < 40) begin @(negedge clk); k++; end
    while (col !== target && k < 80) begin @(negedge clk); k++; end
    if (col !== target) check("wait_col_timeout", 32'(col), 32'(target));
  endtask

  // Scoreboard monitor, sampled 1 time unit after each active edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (key_valid === 1'b1) begin
      pulse_count++;
      last_pulse_cyc = cyc;
      check("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("pulse_key_code", 32'(key_code), 32'(mon_e.code));
        check("pulse_entry", 32'(entry), 32'(mon_e.entry));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_col;
    tbl[0] = '{0, 0, 4'h1, 24'h000001};
    tbl[1] = '{0, 1, 4'h2, 24'h000012};
    tbl[2] = '{0, 2, 4'h3, 24'h000123};
    tbl[3] = '{0, 3, 4'hA, 24'h00123A};
    tbl[4] = '{1, 0, 4'h4, 24'h0123A4};
    tbl[5] = '{1, 1, 4'h5, 24'h123A45};
    tbl[6] = '{1, 2, 4'h6, 24'h23A456};

    pressed   = '0;
    clr       = 1'b0;
    exp_entry = 24'h0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1. Reset values, then idle column stepping.
    check("reset_key_valid", 32'(key_valid), 32'd0);
    check("reset_key_code", 32'(key_code), 32'd0);
    check("reset_entry", 32'(entry), 32'd0);
    for (int k = 0; k < 20; k++) begin
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      check("idle_col", 32'(col), 32'(exp_col));
      @(negedge clk);
    end
    check("idle_no_pulse", 32'(pulse_count), 32'd0);

    // 2. Key '5' held 200 clk: one pulse, exact latency, column frozen.
    wait_col(4'b1101);
    c0 = cyc; p0 = pulse_count;
    push_key(4'h5, 1'b0);
    pressed[1*4+1] = 1'b1;
    repeat (200) @(negedge clk);
    check("k5_pulses", 32'(pulse_count - p0), 32'd1);
    check("k5_latency", 32'(last_pulse_cyc - c0), 32'd12);
    check("k5_col_frozen", 32'(col), 32'(4'b1101));
    check("k5_entry", 32'(entry), 32'h000005);
    pressed = '0;
    n = 0;
    while (col === 4'b1101 && n < 40) begin @(negedge clk); n++; end
    check("k5_resume_col", 32'(col), 32'(4'b1011));

    // 3. Table-driven key sequence after clearing the entry.
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    exp_entry = 24'h0;
    check("clr_entry", 32'(entry), 32'd0);
    p0 = pulse_count;
    for (int i = 0; i < 7; i++) begin
      repeat ($urandom_range(0, 15)) @(negedge clk);
      push_key(tbl[i].code, 1'b0);
      pressed[tbl[i].r*4 + tbl[i].c] = 1'b1;
      repeat (60) @(negedge clk);
      pressed = '0;
      repeat (60) @(negedge clk);
      check("seq_entry", 32'(entry), 32'(tbl[i].entry));
    end
    check("seq_pulses", 32'(pulse_count - p0), 32'd7);

    // 4a. 'F' low for one tick only: no pulse, back to scanning after one tick.
    p0 = pulse_count;
    wait_col(4'b1011);
    pressed[3*4+2] = 1'b1;
    repeat (4) @(negedge clk);
    pressed = '0;
    n = 4;
    while (col !== 4'b0111 && n < 20) begin @(negedge clk); n++; end
    check("bounce_return_time", 32'(n), 32'd8);
    repeat (40) @(negedge clk);
    check("bounce_no_pulse", 32'(pulse_count - p0), 32'd0);

    // 4b. Release bounce while holding '9': no second pulse, still frozen.
    wait_col(4'b1011);
    p0 = pulse_count;
    push_key(4'h9, 1'b0);
    pressed[2*4+2] = 1'b1;
    repeat (20) @(negedge clk);
    check("k9_pulse", 32'(pulse_count - p0), 32'd1);
    pressed = '0;
    repeat (4) @(negedge clk);
    pressed[2*4+2] = 1'b1;
    repeat (40) @(negedge clk);
    check("hold_bounce_frozen", 32'(col), 32'(4'b1011));
    check("hold_bounce_no_repeat", 32'(pulse_count - p0), 32'd1);
    pressed = '0;
    n = 0;
    while (col === 4'b1011 && n < 30) begin @(negedge clk); n++; end
    check("hold_release_resume", 32'(col), 32'(4'b0111));

    // 5. '4' and '7' together with clr on the accept edge.
    repeat (20) @(negedge clk);
    wait_col(4'b1110);
    c0 = cyc; p0 = pulse_count;
    push_key(4'h4, 1'b1);
    pressed[1*4+0] = 1'b1;
    pressed[2*4+0] = 1'b1;
    repeat (11) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("dual_clr_valid", 32'(key_valid), 32'd1);
    check("dual_clr_code", 32'(key_code), 32'h4);
    check("dual_clr_entry", 32'(entry), 32'd0);
    check("dual_clr_latency", 32'(last_pulse_cyc - c0), 32'd12);
    pressed = '0;
    repeat (60) @(negedge clk);
    check("dual_pulses", 32'(pulse_count - p0), 32'd1);

    // 6. rst while debouncing '0', then a clean '0' press.
    wait_col(4'b1101);
    p0 = pulse_count;
    pressed[3*4+1] = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    pressed = '0;
    @(negedge clk);
    rst = 1'b0;
    exp_entry = 24'h0;
    check("rst_mid_col", 32'(col), 32'(4'b1110));
    check("rst_mid_valid", 32'(key_valid), 32'd0);
    check("rst_mid_code", 32'(key_code), 32'd0);
    check("rst_mid_entry", 32'(entry), 32'd0);
    repeat (60) @(negedge clk);
    check("rst_mid_no_pulse", 32'(pulse_count - p0), 32'd0);
    repeat ($urandom_range(0, 15)) @(negedge clk);
    push_key(4'h0, 1'b0);
    pressed[3*4+1] = 1'b1;
    repeat (60) @(negedge clk);
    pressed = '0;
    repeat (60) @(negedge clk);
    check("k0_pulses", 32'(pulse_count - p0), 32'd1);
    check("k0_code", 32'(key_code), 32'h0);
    check("k0_entry", 32'(entry), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
Input-side counterpart of the 8-digit seven-segment display multiplexer. It scans a 4x4 matrix hex keypad by driving one column low at a time and debouncing the row returns. Each accepted key is reported as a 4-bit code, and its hex digit is shifted into a 24-bit entry register. That register drives the display's lower six digits, dato[23:0].

Parameters:
SCAN_DIV, 100000, clk cycles per scan tick (1 kHz at 100 MHz); must be >= 4
DEBOUNCE_TICKS, 4, consecutive stable ticks required for press accept and for release accept; must be >= 2

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
row  in  4  keypad rows, active-low (pulled up), asynchronous to clk
clr  in  1  synchronous clear of entry register
col  out 4  keypad column drive, active-low, exactly one bit low
key_code  out 4  code of last accepted key
key_valid  out 1  one-clk pulse per accepted key
entry  out 24  six hex digits, newest in [3:0]

Behaviour:
- Reset values (rst high at a clk edge): state=SCAN, colsel=0, col=4'b1110, key_code=0, key_valid=0, entry=0, tick and debounce counters=0, row synchroniser=4'b1111.
- rst takes effect mid-operation in any state. A press in DEBOUNCE when rst hits produces no pulse.
- Row synchroniser: two flops, row_s = row delayed 2 clk.
- Tick: a counter runs 0..SCAN_DIV-1, and tick=1 for one clk when the count equals SCAN_DIV-1. The counter free-runs in every state.
- col = ~(4'b0001 << colsel), registered. Decisions are taken only on tick, so rows have at least SCAN_DIV-2 cycles to settle after a column change.
- hit = row_s != 4'b1111. sel_row = lowest index r with row_s[r]=0; the lower row wins when several rows are low.
- Key map (row r, col c):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E(*),0,F(#),D
- SCAN state, on tick:
  - If hit: latch cand_row=sel_row and cand_col=colsel, set cnt=1, go to DEBOUNCE. colsel is held.
  - Otherwise: colsel=colsel+1, wrapping 3 to 0.
- DEBOUNCE state (col frozen), on tick:
  - If row_s[cand_row]=0: cnt=cnt+1. When cnt+1 = DEBOUNCE_TICKS:
    - key_valid=1 for exactly the next clk cycle;
    - key_code = map(cand_row, cand_col);
    - entry = {entry[19:0], code};
    - go to HOLD with cnt=0.
  - Otherwise: go to SCAN and advance colsel.
- HOLD state (col frozen, no auto-repeat), on tick:
  - If row_s == 4'b1111: cnt=cnt+1. When cnt+1 = DEBOUNCE_TICKS: go to SCAN, advance colsel, cnt=0.
  - Otherwise: cnt=0.
- Latency: key_valid is asserted on the clk after the DEBOUNCE_TICKS-th consecutive low-sampling tick.
- clr: entry=0 on the next edge in any state; scanning is unaffected.
- clr coincident with an accept: entry=0 (clr wins), but key_valid and key_code are still updated.
- entry shifting drops the oldest digit (entry[23:20]) with no saturation. key_code holds its value between pulses.

Test Plan:
(Bench: SCAN_DIV=4, DEBOUNCE_TICKS=3. The keypad model drives row[r]=0 while col[c]=0 and key (r,c) is pressed.)
1. Reset and idle, all rows high -> col=1110 after reset, then steps 1101, 1011, 0111, 1110, each held 4 clk; key_valid never asserts; entry=0.
2. Key '5' (r1,c1) held 200 clk -> exactly one key_valid pulse, key_code=5, entry=24'h000005; col stays 1101 until the key is released for 3 ticks, then scanning resumes at 1011.
3. Keys 1,2,3,A,4,5,6 in sequence, each held 60 clk then released 60 clk -> seven pulses; entry ends at 24'h23A456 (leading '1' shifted out).
4. Bounce: 'F' (r3,c2) low for 1 tick then released -> no pulse, return to SCAN. Bounce during HOLD: release 1 tick, press again -> no second pulse, still in HOLD.
5. Keys '4' and '7' (same column) pressed together -> key_code=4 only. clr pulsed on the accept cycle -> key_valid=1, key_code=4, entry=0.
6. rst asserted while in DEBOUNCE with key '0' held -> no pulse, outputs at reset values. After release, a subsequent '0' press yields key_code=0 and entry=24'h000000 with key_valid=1.
